// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: expands single-byte I2C register read/write commands into
// START/TX/RX/STOP primitives on the I2C controller's Avalon-MM register map.
module i2c_txn_sequencer #(
  parameter logic [15:0] CLK_DIV = 16'd250,
  parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_dev_addr,
  input  logic [7:0]  cmd_reg_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_status,
  output logic [2:0]  avm_m0_address,
  output logic        avm_m0_read,
  input  logic [31:0] avm_m0_readdata,
  output logic        avm_m0_write,
  output logic [31:0] avm_m0_writedata,
  input  logic        avm_m0_irq
);
  typedef enum logic [3:0] {
    S_BOOT, S_INIT_DIV, S_INIT_CLR, S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_STAT, S_RXD, S_CLR, S_RESP
  } state_t;
  localparam logic [7:0] OP_START = 8'h01, OP_STOP = 8'h02, OP_TX = 8'h04, OP_RXN = 8'h10, INT_CLR = 8'h20;
  localparam logic [1:0] ST_OK = 2'd0, ST_NACK = 2'd1, ST_TIMEOUT = 2'd2;

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d, wdata_q, wdata_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  status_q, status_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [2:0]  addr_q, addr_d;
  logic        rd_q, rd_d, wr_q, wr_d, ready_q, ready_d, valid_q, valid_d;
  logic [31:0] wdat_q, wdat_d;
  logic [7:0]  op_q, op_d, byte_d;
  logic [2:0]  stop_idx;
  logic        unused_rdata;

  // Write: S TX TX TX P.  Read: S TX TX S TX RXN P.
  function automatic logic [7:0] op_of(input logic rw, input logic [2:0] s);
    return s == 3'd0 ? OP_START :
           rw ? (s == 3'd3 ? OP_START : s == 3'd5 ? OP_RXN : s == 3'd6 ? OP_STOP : OP_TX) :
                (s == 3'd4 ? OP_STOP : OP_TX);
  endfunction

  function automatic logic [7:0] byte_of(input logic rw, input logic [2:0] s, input logic [6:0] dev,
                                         input logic [7:0] rg, input logic [7:0] wd);
    return s == 3'd1 ? {dev, 1'b0} : s == 3'd2 ? rg : rw ? {dev, 1'b1} : wd;
  endfunction

  assign op_q     = op_of(rw_q, step_q);
  assign op_d     = op_of(rw_d, step_d);
  assign byte_d   = byte_of(rw_d, step_d, dev_d, reg_d, wdata_d);
  assign stop_idx = rw_q ? 3'd6 : 3'd4;
  assign unused_rdata = ^avm_m0_readdata[31:8];

  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_BOOT:     state_d = S_INIT_DIV;
      S_INIT_DIV: state_d = S_INIT_CLR;
      S_INIT_CLR: state_d = S_IDLE;
      S_IDLE: if (cmd_valid && ready_q) begin
        rw_d     = cmd_rw;
        dev_d    = cmd_dev_addr;
        reg_d    = cmd_reg_addr;
        wdata_d  = cmd_wdata;
        step_d   = 3'd0;
        status_d = ST_OK;
        rdata_d  = 8'h00;
        state_d  = S_ISSUE;
      end
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: begin
        cnt_d   = 32'd0;
        state_d = S_WAIT;
      end
      S_WAIT: if (avm_m0_irq) state_d = S_STAT;
        else if (cnt_q == TIMEOUT - 32'd1) begin
          status_d = ST_TIMEOUT;
          rdata_d  = 8'h00;
          state_d  = S_CLR;
        end else cnt_d = cnt_q + 32'd1;
      S_STAT: begin
        if (op_q == OP_TX && avm_m0_readdata[1]) status_d = ST_NACK;
        state_d = op_q == OP_RXN ? S_RXD : S_CLR;
      end
      S_RXD: begin
        rdata_d = avm_m0_readdata[7:0];
        state_d = S_CLR;
      end
      // A NACK skips straight to STOP; a timeout abandons the bus without STOP.
      S_CLR: if (status_q == ST_TIMEOUT || op_q == OP_STOP) state_d = S_RESP;
        else begin
          step_d  = status_q == ST_NACK ? stop_idx : step_q + 3'd1;
          state_d = op_of(rw_q, step_d) == OP_TX ? S_LOAD : S_ISSUE;
        end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_BOOT;
    endcase
  end

  // Bus outputs are registered from the state being entered.
  always_comb begin
    wr_d    = state_d inside {S_INIT_DIV, S_INIT_CLR, S_LOAD, S_ISSUE, S_CLR};
    rd_d    = state_d inside {S_STAT, S_RXD};
    addr_d  = state_d == S_INIT_DIV ? 3'd2 : state_d == S_LOAD ? 3'd1 : state_d == S_STAT ? 3'd4 :
              state_d inside {S_INIT_CLR, S_ISSUE, S_CLR} ? 3'd3 : 3'd0;
    wdat_d  = state_d == S_INIT_DIV ? {16'h0, CLK_DIV} : state_d == S_LOAD ? {24'h0, byte_d} :
              state_d == S_ISSUE ? {24'h0, op_d} : state_d inside {S_INIT_CLR, S_CLR} ? {24'h0, INT_CLR} : 32'h0;
    ready_d = state_d == S_IDLE;
    valid_d = state_d == S_RESP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_BOOT;
      rw_q     <= 1'b0;
      dev_q    <= 7'h0;
      reg_q    <= 8'h0;
      wdata_q  <= 8'h0;
      step_q   <= 3'd0;
      cnt_q    <= 32'd0;
      status_q <= ST_OK;
      rdata_q  <= 8'h0;
      addr_q   <= 3'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdat_q   <= 32'h0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdat_q   <= wdat_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

  assign cmd_ready        = ready_q;
  assign rsp_valid        = valid_q;
  assign rsp_rdata        = rdata_q;
  assign rsp_status       = status_q;
  assign avm_m0_address   = addr_q;
  assign avm_m0_read      = rd_q;
  assign avm_m0_write     = wr_q;
  assign avm_m0_writedata = wdat_q;
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: drives commands into the sequencer against a behavioural
// I2C controller and compares bus traffic and responses with a primitive-list model.
module tb_i2c_txn_sequencer;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_ready, cmd_rw = 0;
  logic [6:0] cmd_dev_addr = 0;
  logic [7:0] cmd_reg_addr = 0, cmd_wdata = 0;
  logic rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_status;
  logic [2:0] avm_m0_address;
  logic avm_m0_read, avm_m0_write, avm_m0_irq;
  logic [31:0] avm_m0_readdata, avm_m0_writedata;
  int checks = 0, errors = 0, cyc = 0;

  i2c_txn_sequencer #(.CLK_DIV(16'd250), .TIMEOUT(32'd100)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .avm_m0_address(avm_m0_address), .avm_m0_read(avm_m0_read), .avm_m0_readdata(avm_m0_readdata),
    .avm_m0_write(avm_m0_write), .avm_m0_writedata(avm_m0_writedata), .avm_m0_irq(avm_m0_irq));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural controller: logs accesses, raises irq a few cycles after each op.
  logic irq_r = 0, ack_r = 0;
  logic [7:0] rx_byte = 0;
  int nack_tx = -1, hang_prim = -1, prim_n = 0, tx_n = 0, irq_cnt = 0, overlap = 0;
  logic [31:0] ctrl_log[$], div_log[$], exp_ops[$];
  logic [7:0] tx_log[$], exp_tx[$];
  int start_cyc[$];

  assign avm_m0_irq = irq_r;
  assign avm_m0_readdata = !avm_m0_read ? 32'h0 : avm_m0_address == 3'd4 ? {29'd0, irq_r, ack_r, 1'b0} :
                           avm_m0_address == 3'd0 ? {24'd0, rx_byte} : 32'h0;

  always @(negedge clk) begin : ctrl_model
    int d;
    if (avm_m0_read && avm_m0_write) overlap++;
    if (irq_cnt > 0) begin
      irq_cnt--;
      if (irq_cnt == 0) irq_r = 1;
    end
    if (avm_m0_write) begin
      if (avm_m0_address == 3'd1) tx_log.push_back(avm_m0_writedata[7:0]);
      if (avm_m0_address == 3'd2) div_log.push_back(avm_m0_writedata);
      if (avm_m0_address == 3'd3) begin
        ctrl_log.push_back(avm_m0_writedata);
        if (avm_m0_writedata == 32'h20) begin
          irq_r = 0;
          irq_cnt = 0;
        end else begin
          if (avm_m0_writedata == 32'h1) start_cyc.push_back(cyc);
          ack_r = avm_m0_writedata == 32'h4 ? (tx_n == nack_tx) : 1'($urandom);
          if (avm_m0_writedata == 32'h4) tx_n++;
          if (prim_n != hang_prim) begin
            d = $urandom_range(0, 3);
            if (d == 0) irq_r = 1; else irq_cnt = d;
          end
          prim_n++;
        end
      end
    end
  end

  typedef struct {
    logic rw; logic [6:0] dev; logic [7:0] rg; logic [7:0] wd; logic [7:0] rx;
    int nack; int hang; logic [1:0] st; logic [7:0] rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: walk the command's primitive list, applying NACK/timeout rules.
  task automatic ref_model(input vec_t v, output logic [1:0] st, output logic [7:0] rd);
    logic [7:0] ops[$], bytes[$];
    int ntx = 0;
    exp_ops.delete();
    exp_tx.delete();
    if (v.rw) begin
      ops = '{8'h01, 8'h04, 8'h04, 8'h01, 8'h04, 8'h10, 8'h02};
      bytes = '{8'h0, {v.dev, 1'b0}, v.rg, 8'h0, {v.dev, 1'b1}, 8'h0, 8'h0};
    end else begin
      ops = '{8'h01, 8'h04, 8'h04, 8'h04, 8'h02};
      bytes = '{8'h0, {v.dev, 1'b0}, v.rg, v.wd, 8'h0};
    end
    st = 0;
    for (int i = 0; i < ops.size(); i++) begin
      if (ops[i] == 8'h04) exp_tx.push_back(bytes[i]);
      exp_ops.push_back({24'h0, ops[i]});
      exp_ops.push_back(32'h20);
      if (i == v.hang) begin
        st = 2;
        break;
      end
      if (ops[i] == 8'h04) begin
        if (ntx == v.nack) begin
          st = 1;
          exp_ops.push_back(32'h02);
          exp_ops.push_back(32'h20);
          break;
        end
        ntx++;
      end
    end
    rd = (st == 0 && v.rw) ? v.rx : 8'h0;
  endtask

  task automatic setup_model(input vec_t v);
    prim_n = 0; tx_n = 0; nack_tx = v.nack; hang_prim = v.hang; rx_byte = v.rx;
    ctrl_log.delete(); tx_log.delete(); start_cyc.delete();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 1);
  endtask

  task automatic run_cmd(input vec_t v, input bit use_table, output int rsp_cyc);
    logic [1:0] st, est;
    logic [7:0] rd, erd;
    bit got = 0, busy_ok = 1;
    setup_model(v);
    wait_ready();
    cmd_valid = 1; cmd_rw = v.rw; cmd_dev_addr = v.dev; cmd_reg_addr = v.rg; cmd_wdata = v.wd;
    @(posedge clk);
    #1 cmd_valid = 0;
    rsp_cyc = -1; st = 0; rd = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1; rsp_cyc = cyc; st = rsp_status; rd = rsp_rdata;
      end else if (cmd_ready) busy_ok = 0;
    end
    chk("rsp_seen", 32'(got), 1);
    chk("busy_ready_low", 32'(busy_ok), 1);
    @(negedge clk);
    chk("rsp_one_cycle", 32'(rsp_valid), 0);
    chk("ready_after_rsp", 32'(cmd_ready), 1);
    ref_model(v, est, erd);
    if (use_table) begin
      est = v.st;
      erd = v.rd;
    end
    chk("rsp_status", 32'(st), 32'(est));
    chk("rsp_rdata", 32'(rd), 32'(erd));
    chk("ctrl_count", ctrl_log.size(), exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < ctrl_log.size(); i++)
      chk($sformatf("ctrl_op[%0d]", i), ctrl_log[i], exp_ops[i]);
    chk("tx_count", tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      chk($sformatf("txdata[%0d]", i), 32'(tx_log[i]), 32'(exp_tx[i]));
  endtask

  vec_t vecs[8];
  vec_t v;
  int rc, r_cyc[2], rs, nrsp, nstop;

  initial begin
    vecs[0] = '{1'b0, 7'h50, 8'h10, 8'h3C, 8'h00, -1, -1, 2'd0, 8'h00};
    vecs[1] = '{1'b1, 7'h50, 8'h22, 8'h00, 8'hA5, -1, -1, 2'd0, 8'hA5};
    vecs[2] = '{1'b0, 7'h50, 8'h10, 8'h3C, 8'h00,  0, -1, 2'd1, 8'h00};
    vecs[3] = '{1'b1, 7'h29, 8'h05, 8'h00, 8'h77,  2, -1, 2'd1, 8'h00};
    vecs[4] = '{1'b0, 7'h7F, 8'hFF, 8'h00, 8'h00,  2, -1, 2'd1, 8'h00};
    vecs[5] = '{1'b1, 7'h00, 8'h00, 8'h00, 8'hFF, -1, -1, 2'd0, 8'hFF};
    vecs[6] = '{1'b1, 7'h50, 8'h22, 8'h00, 8'h5A, -1,  5, 2'd2, 8'h00};
    vecs[7] = '{1'b0, 7'h12, 8'h34, 8'h56, 8'h00, -1,  4, 2'd2, 8'h00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_address", 32'(avm_m0_address), 0);
    chk("rst_read", 32'(avm_m0_read), 0);
    chk("rst_write", 32'(avm_m0_write), 0);
    chk("rst_writedata", avm_m0_writedata, 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_rsp_status", 32'(rsp_status), 0);
    reset = 0;
    @(negedge clk);
    chk("init1_write", 32'(avm_m0_write), 1);
    chk("init1_addr", 32'(avm_m0_address), 2);
    chk("init1_data", avm_m0_writedata, 32'hFA);
    chk("init1_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    chk("init2_write", 32'(avm_m0_write), 1);
    chk("init2_addr", 32'(avm_m0_address), 3);
    chk("init2_data", avm_m0_writedata, 32'h20);
    @(negedge clk);
    chk("init3_ready", 32'(cmd_ready), 1);
    chk("init3_write", 32'(avm_m0_write), 0);

    foreach (vecs[i]) run_cmd(vecs[i], 1'b1, rc);

    // Timeout on START: 100 WAIT cycles, then CLR, then the response.
    v = '{1'b0, 7'h50, 8'h10, 8'h3C, 8'h00, -1, 0, 2'd2, 8'h00};
    run_cmd(v, 1'b1, rc);
    chk("timeout_start_seen", start_cyc.size(), 1);
    if (start_cyc.size() > 0) chk("timeout_latency", rc - start_cyc[0], 102);
    run_cmd(vecs[0], 1'b1, rc);

    for (int k = 0; k < 30; k++) begin
      v.rw = 1'($urandom); v.dev = 7'($urandom); v.rg = 8'($urandom);
      v.wd = 8'($urandom); v.rx = 8'($urandom);
      v.nack = $urandom_range(0, 1) ? -1 : $urandom_range(0, v.rw ? 2 : 2);
      v.hang = (v.nack < 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, v.rw ? 6 : 4) : -1;
      run_cmd(v, 1'b0, rc);
    end

    // cmd_valid held high across two writes.
    v = '{1'b0, 7'h33, 8'h01, 8'h5A, 8'h00, -1, -1, 2'd0, 8'h00};
    setup_model(v);
    wait_ready();
    cmd_valid = 1; cmd_rw = 0; cmd_dev_addr = v.dev; cmd_reg_addr = v.rg; cmd_wdata = v.wd;
    rs = 0;
    for (int n = 0; n < 300 && rs < 2; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        r_cyc[rs] = cyc;
        rs++;
        if (rs == 2) cmd_valid = 0;
      end
    end
    cmd_valid = 0;
    chk("b2b_rsp_count", rs, 2);
    chk("b2b_start_count", start_cyc.size(), 2);
    if (rs == 2 && start_cyc.size() == 2) chk("b2b_second_start", start_cyc[1] - r_cyc[0], 2);

    // Reset pulsed while a third command waits for irq.
    v = '{1'b1, 7'h44, 8'h02, 8'h00, 8'h11, -1, 0, 2'd0, 8'h00};
    setup_model(v);
    wait_ready();
    cmd_valid = 1; cmd_rw = 1; cmd_dev_addr = v.dev; cmd_reg_addr = v.rg;
    @(posedge clk);
    #1 cmd_valid = 0;
    repeat (10) @(negedge clk);
    div_log.delete();
    ctrl_log.delete();
    reset = 1;
    @(negedge clk);
    reset = 0;
    nrsp = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    nstop = 0;
    foreach (ctrl_log[i]) if (ctrl_log[i] == 32'h02) nstop++;
    chk("abort_no_rsp", nrsp, 0);
    chk("abort_no_stop", nstop, 0);
    chk("abort_reinit_count", div_log.size(), 1);
    if (div_log.size() > 0) chk("abort_reinit_div", div_log[0], 32'hFA);
    chk("abort_ready", 32'(cmd_ready), 1);
    run_cmd(vecs[1], 1'b1, rc);

    chk("strobe_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
